dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (async read, sync write) between two requesters:
//  port 0 = core load/store unit, port 1 = UART program/data loader.
//  Arbitrates per cycle, supports locked bursts, and drives the memory address, write
//  data and write enable. Returns registered read data one cycle after acceptance.
//  Sits between the core/loader and the data memory instance.
// PARAMETERS
//  DEPTH   50001  number of 32-bit words in data memory; valid word addresses are 0..DEPTH-1
//  AW      32     address width of requester and memory ports (word address)
//  DW      32     data width
// PORTS
//  clk        in   1    system clock, all state updates on posedge
//  rstn       in   1    asynchronous active-low reset
//  m0_req     in   1    port 0 request valid; held with fields until m0_gnt
//  m0_we      in   1    port 0 write (1) / read (0)
//  m0_addr    in   AW   port 0 word address
//  m0_wdata   in   DW   port 0 write data
//  m0_lock    in   1    port 0 keeps ownership after this transfer
//  m0_gnt     out  1    port 0 request accepted this cycle (combinational)
//  m0_rvalid  out  1    port 0 read data valid (1-cycle pulse)
//  m0_rdata   out  DW   port 0 read data
//  m1_*       --   --   identical set for port 1
//  mem_we     out  1    memory write enable
//  mem_a      out  AW   memory word address
//  mem_wd     out  DW   memory write data
//  mem_rd     in   DW   memory async read data for mem_a
// BEHAVIOUR
//  - States: IDLE, LOCK0, LOCK1 (2-bit reg). Reset -> IDLE.
//  - Reset: gnt 0 (no req), rvalid 0, rdata 0, state IDLE, rr pointer = port 0.
//  - Grant (combinational): IDLE: per the priority rule below. LOCKn: only port n is granted;
//    the other port waits, even if it is requesting.
//  - Accept = req & gnt at posedge. Exactly one port is granted per cycle.
//  - mem_a / mem_wd come from the granted port, else from port 0.
//    mem_we = accept & we & (addr < DEPTH).
//  - Read: on accept with we=0, rdata <= (addr < DEPTH) ? mem_rd : 0. rvalid pulses high the
//    next cycle on that port only. rdata holds its value until the next read.
//  - Out-of-range write: dropped silently, and still granted.
//  - Write: committed at the accept edge. There is no response.
//  - Back-to-back accepts are allowed every cycle. A read after a write to the same address
//    in the next cycle returns the new data.
//  - Lock: an accept with lock=1 moves the state to LOCKn.
//    In LOCKn, an accept by port n with lock=0 returns the state to IDLE.
//    req=0 does not release the lock.
//  - Reset mid-transfer: a pending rvalid is squashed and no write occurs after reset.
//  - Simultaneous requests in IDLE: resolved per CONFIGURATION.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin in IDLE.
//    On a tie, the port not granted last wins. The pointer updates on every accept.
//  DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. No pointer register.
// STRUCTURE
//  - Shared package dmem_pkg: state encodings (ST_IDLE, ST_LOCK0, ST_LOCK1),
//    DEPTH default, AW/DW widths.
//  - Single module. There is no sub-module; the grant logic is small enough to stay inline.
// TESTING
//  1. Reset: rstn=0 with m0_req=1 -> m0_gnt=1 combinational, no mem_we, rvalid=0, rdata=0.
//  2. m0 writes 0xDEADBEEF @5, next cycle m0 reads @5
//     -> m0_rvalid=1 one cycle later, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
//  3. Both read @1/@2 for 4 cycles:
//     - RR: grants alternate 0,1,0,1.
//     - Fixed: m0 granted every cycle, m1_gnt=0.
//  4. m1 lock=1 read @10, lock=1 read @11, lock=0 read @12, m0_req held high throughout
//     -> m0_gnt=0 for those 3 cycles, m0 granted on the 4th.
//  5. m0 write 0x1234 @50001 -> mem_we=0, m0_gnt=1. Read @50001 -> rvalid=1, rdata=0.
//  6. rstn asserted the cycle after a read accept -> rvalid stays 0, state IDLE, lock cleared.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned DMEM_DEPTH = 50001;
   localparam int unsigned DMEM_AW    = 32;
   localparam int unsigned DMEM_DW    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (core LSU on port 0, UART loader on port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking in IDLE; otherwise port 0 wins ties.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = DMEM_DEPTH,
   parameter int unsigned AW    = DMEM_AW,
   parameter int unsigned DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          rstn,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,

   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   state_e          state_q, state_d;
   logic            rv0_q, rv0_d, rv1_q, rv1_d;
   logic [DW-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;

   logic            gnt0, gnt1, acc;
   logic            sel_we, sel_lock, in_range;
   logic [DW-1:0]   rd_sel;

`ifdef DMEM_ARB_RR_EN
   // rr_q names the port that wins the next IDLE tie
   logic            rr_q, rr_d;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state_q)
         ST_LOCK0: gnt0 = m0_req;
         ST_LOCK1: gnt1 = m1_req;
         default: begin
`ifdef DMEM_ARB_RR_EN
            if (m0_req && m1_req) begin
               gnt0 = ~rr_q;
               gnt1 = rr_q;
            end else begin
               gnt0 = m0_req;
               gnt1 = m1_req;
            end
`else
            gnt0 = m0_req;
            gnt1 = m1_req & ~m0_req;
`endif
         end
      endcase
   end

   assign acc      = gnt0 | gnt1;
   assign mem_a    = gnt1 ? m1_addr  : m0_addr;
   assign mem_wd   = gnt1 ? m1_wdata : m0_wdata;
   assign sel_we   = gnt1 ? m1_we    : m0_we;
   assign sel_lock = gnt1 ? m1_lock  : m0_lock;
   assign in_range = (mem_a < AW'(DEPTH));
   assign rd_sel   = in_range ? mem_rd : '0;

   // rstn gate keeps a request held through reset from reaching the memory
   assign mem_we   = rstn & acc & sel_we & in_range;

   always_comb begin
      state_d = state_q;
      rv0_d   = gnt0 & ~m0_we;
      rv1_d   = gnt1 & ~m1_we;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
`ifdef DMEM_ARB_RR_EN
      rr_d    = rr_q;
`endif
      if (rv0_d) rd0_d = rd_sel;
      if (rv1_d) rd1_d = rd_sel;
      if (acc) begin
         if (sel_lock) state_d = gnt1 ? ST_LOCK1 : ST_LOCK0;
         else          state_d = ST_IDLE;
`ifdef DMEM_ARB_RR_EN
         rr_d = gnt0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rv0_q   <= rv0_d;
         rv1_q   <= rv1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
`ifdef DMEM_ARB_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign m0_rvalid = rv0_q;
   assign m1_rvalid = rv1_q;
   assign m0_rdata  = rd0_q;
   assign m1_rdata  = rd1_q;

endmodule
